escalonador_sensores: RTL and testbench

Sequencing controller for the 8-sensor acquisition datapath. It replaces the free-running address counter with request-driven, round-robin polling. It drives the MUX select address and handshakes each 11-bit packet with the transmitter. It also consumes the parity-error/resend indication to retry a packet or declare a delivery failure.

---
 rtl/escalonador_sensores.sv | 127 ++++++++++++
 tb/tb_escalonador_sensores.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/escalonador_sensores.sv
// Round-robin sequencer for the 8-sensor acquisition path: selects a requesting
// sensor, hands its packet to the transmitter and retries on parity error or ack timeout.
module escalonador_sensores #(
  parameter int N_SENS      = 8,
  parameter int MAX_RETRY   = 3,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_SENS-1:0] req,
  input  logic              tx_ready,
  input  logic              ack,
  input  logic              erro,
  output logic [2:0]        endereco,
  output logic              tx_valid,
  output logic [N_SENS-1:0] grant,
  output logic              falha,
  output logic              ocupado
);

  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [RTY_W-1:0]  RTY_MAX = RTY_W'(MAX_RETRY);
  localparam logic [TMR_W-1:0]  TMR_MAX = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [N_SENS-1:0] ONE     = N_SENS'(1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

  state_t            state_q;
  logic [RTY_W-1:0]  retry_q;
  logic [TMR_W-1:0]  timer_q;
  logic [2:0]        ptr_q;
  logic [2:0]        endereco_q;
  logic              tx_valid_q;
  logic [N_SENS-1:0] grant_q;
  logic              falha_q;
  logic              ocupado_q;

  logic [2:0]        pick_d;
  logic              found_d;
  int unsigned       idx;

  // Search starts just past the last served sensor, so a sensor that was
  // just granted becomes the lowest priority.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    found_d = 1'b0;
    pick_d  = '0;
    idx     = 0;
    for (int i = 1; i <= N_SENS; i++) begin
      idx = (int'(ptr_q) + i) % N_SENS;
      if (!found_d && req[idx]) begin
        found_d = 1'b1;
        pick_d  = 3'(idx);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      retry_q    <= '0;
      timer_q    <= '0;
      ptr_q      <= 3'(N_SENS - 1);
      endereco_q <= '0;
      tx_valid_q <= 1'b0;
      grant_q    <= '0;
      falha_q    <= 1'b0;
      ocupado_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found_d) begin
            endereco_q <= pick_d;
            retry_q    <= '0;
            tx_valid_q <= 1'b1;
            ocupado_q  <= 1'b1;
            state_q    <= SEND;
          end
        end
        SEND: begin
          if (tx_ready) begin
            tx_valid_q <= 1'b0;
            timer_q    <= '0;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          // A clean ack takes priority over a timeout expiring in the same cycle.
          if (ack && !erro) begin
            grant_q <= ONE << endereco_q;
            state_q <= DONE;
          end else if (ack || timer_q == TMR_MAX) begin
            if (retry_q < RTY_MAX) begin
              retry_q    <= retry_q + 1'b1;
              tx_valid_q <= 1'b1;
              state_q    <= SEND;
            end else begin
              grant_q <= ONE << endereco_q;
              falha_q <= 1'b1;
              state_q <= DONE;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        DONE: begin
          grant_q   <= '0;
          falha_q   <= 1'b0;
          ptr_q     <= endereco_q;
          ocupado_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign endereco = endereco_q;
  assign tx_valid = tx_valid_q;
  assign grant    = grant_q;
  assign falha    = falha_q;
  assign ocupado  = ocupado_q;

endmodule

// File: tb/tb_escalonador_sensores.sv
// Directed bench for escalonador_sensores: round-robin order, retries, drops,
// ack timeout, back-pressure and asynchronous reset mid-transaction.
module tb_escalonador_sensores;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       tx_ready;
  logic       ack;
  logic       erro;
  logic [2:0] endereco;
  logic       tx_valid;
  logic [7:0] grant;
  logic       falha;
  logic       ocupado;

  int checks = 0;
  int errors = 0;

  escalonador_sensores #(.N_SENS(8), .MAX_RETRY(3), .ACK_TIMEOUT(15)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .tx_ready (tx_ready),
    .ack      (ack),
    .erro     (erro),
    .endereco (endereco),
    .tx_valid (tx_valid),
    .grant    (grant),
    .falha    (falha),
    .ocupado  (ocupado)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_addr"},  32'(endereco), 0);
    check({tag, "_valid"}, 32'(tx_valid), 0);
    check({tag, "_grant"}, 32'(grant),    0);
    check({tag, "_falha"}, 32'(falha),    0);
    check({tag, "_busy"},  32'(ocupado),  0);
  endtask

  // Called at a falling edge in IDLE with req already set; tx_ready held high,
  // ack given in the first WAIT cycle, erro set on the first n_err acks.
  task automatic serve(input int addr, input int n_err, input bit exp_falha, input int exp_tx);
    int  tx_count = 0;
    bit  done     = 1'b0;
    @(negedge clk);
    check("send_addr",  32'(endereco), 32'(addr));
    check("send_valid", 32'(tx_valid), 1);
    check("send_busy",  32'(ocupado),  1);
    check("send_grant", 32'(grant),    0);
    tx_ready = 1'b1;
    for (int a = 0; a < 8 && !done; a++) begin
      tx_count++;
      @(negedge clk);
      check("wait_valid", 32'(tx_valid), 0);
      check("wait_addr",  32'(endereco), 32'(addr));
      ack  = 1'b1;
      erro = (a < n_err);
      @(negedge clk);
      ack  = 1'b0;
      erro = 1'b0;
      if (grant != 8'h00) begin
        done = 1'b1;
        check("done_grant", 32'(grant),    32'(8'h01 << addr));
        check("done_falha", 32'(falha),    32'(exp_falha));
        check("done_valid", 32'(tx_valid), 0);
        check("done_busy",  32'(ocupado),  1);
      end else begin
        check("retry_valid", 32'(tx_valid), 1);
        check("retry_addr",  32'(endereco), 32'(addr));
      end
    end
    check("done_reached", 32'(done),     1);
    check("tx_count",     32'(tx_count), 32'(exp_tx));
    @(negedge clk);
    check("idle_grant", 32'(grant),   0);
    check("idle_falha", 32'(falha),   0);
    check("idle_busy",  32'(ocupado), 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    req      = 8'h00;
    tx_ready = 1'b0;
    ack      = 1'b0;
    erro     = 1'b0;
    #12;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // All sensors requesting: strict 0..7 then wrap to 0.
    req = 8'hFF;
    for (int i = 0; i < 9; i++) serve(i % 8, 0, 1'b0, 1);
    req = 8'h00;

    // Single request, clean ack.
    req = 8'b0000_0100;
    serve(2, 0, 1'b0, 1);
    req = 8'h00;

    // Stray ack/erro in IDLE must be ignored.
    ack  = 1'b1;
    erro = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("stray_busy",  32'(ocupado),  0);
      check("stray_valid", 32'(tx_valid), 0);
      check("stray_grant", 32'(grant),    0);
    end
    ack  = 1'b0;
    erro = 1'b0;

    // Two parity errors then success.
    req = 8'b0000_0001;
    serve(0, 2, 1'b0, 3);
    req = 8'h00;

    // Errors on every attempt: 1 + MAX_RETRY sends, then drop.
    req = 8'b0010_0000;
    serve(5, 4, 1'b1, 4);
    req = 8'h00;

    // Back-pressure, ack timeout, then ack landing on the expiring cycle.
    tx_ready = 1'b0;
    req      = 8'b0000_1000;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(tx_valid), 1);
      check("bp_addr",  32'(endereco), 3);
      if (i == 0) req = 8'h00;
    end
    tx_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("to_valid", 32'(tx_valid), 0);
      check("to_busy",  32'(ocupado),  1);
      check("to_grant", 32'(grant),    0);
    end
    @(negedge clk);
    check("to_retry_valid", 32'(tx_valid), 1);
    check("to_retry_addr",  32'(endereco), 3);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      check("to2_valid", 32'(tx_valid), 0);
      check("to2_grant", 32'(grant),    0);
    end
    @(negedge clk);
    check("to2_last_valid", 32'(tx_valid), 0);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("edge_ack_grant", 32'(grant),    32'(8'b0000_1000));
    check("edge_ack_falha", 32'(falha),    0);
    check("edge_ack_valid", 32'(tx_valid), 0);
    @(negedge clk);
    check("edge_ack_idle", 32'(ocupado), 0);

    // Asynchronous reset while waiting on sensor 6.
    req = 8'b0100_0000;
    @(negedge clk);
    check("rst_send_addr", 32'(endereco), 6);
    @(negedge clk);
    check("rst_wait_busy", 32'(ocupado), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    @(negedge clk);
    check("rst_held_grant", 32'(grant), 0);
    req   = 8'b0100_0001;
    rst_n = 1'b1;
    serve(0, 0, 1'b0, 1);
    serve(6, 0, 1'b0, 1);
    req = 8'h00;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
